// File: rtl/matvec_job_arbiter.sv
// matvec_job_arbiter
//
// Purpose: shares one matvec8 engine (8x8 matrix, 8-vector) between NREQ
// requesters. Jobs are granted round-robin. A job either loads a new matrix
// plus a vector, or loads a vector only and reuses the resident matrix. The
// granted requester's input stream is muxed to the engine, and the engine's
// 8 results are routed back to that requester. The arbiter refuses a
// vector-only job unless that requester owns the matrix currently held in
// the engine.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset (shared with engine)
//   job_req[NREQ]         level job request, held until job_ack or job_rej
//   job_new_matrix[NREQ]  1 = job loads matrix then vector, 0 = vector only
//   job_ack/job_rej       one-hot single-cycle accept / refuse pulses
//   in_valid/in_ready     per-requester input word handshake
//   in_data               packed input words, requester i at slice i
//   rsp_valid/rsp_ready   per-requester result handshake
//   rsp_data              result word, broadcast to all requesters
//   busy                  a job is in progress
//   eng_*                 streams to and from the matvec8 engine
//
// States:
//   IDLE  | arbitrate among job_req, issue one ack or rej per cycle
//   LOAD  | owner's input stream connected to engine input
//   DRAIN | engine results routed to owner until 8 are taken
module matvec_job_arbiter #(
  parameter int NREQ      = 2,
  parameter int WIDTH_IN  = 14,
  parameter int WIDTH_OUT = 28,
  parameter int SIZE_W    = 64,
  parameter int SIZE_X    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          job_req,
  input  logic [NREQ-1:0]          job_new_matrix,
  output logic [NREQ-1:0]          job_ack,
  output logic [NREQ-1:0]          job_rej,
  input  logic [NREQ-1:0]          in_valid,
  output logic [NREQ-1:0]          in_ready,
  input  logic [NREQ*WIDTH_IN-1:0] in_data,
  output logic [NREQ-1:0]          rsp_valid,
  input  logic [NREQ-1:0]          rsp_ready,
  output logic [WIDTH_OUT-1:0]     rsp_data,
  output logic                     busy,
  output logic                     eng_input_valid,
  input  logic                     eng_input_ready,
  output logic [WIDTH_IN-1:0]      eng_input_data,
  output logic                     eng_new_matrix,
  input  logic                     eng_output_valid,
  output logic                     eng_output_ready,
  input  logic [WIDTH_OUT-1:0]     eng_output_data
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] rr_ptr, rr_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [IW-1:0] mat_owner, mat_owner_nxt;
  logic          mat_valid, mat_valid_nxt;
  logic          nm, nm_nxt;
  logic [6:0]    word_cnt, word_cnt_nxt;
  logic [6:0]    word_last;
  logic [2:0]    res_cnt, res_cnt_nxt;
  logic          res_done;

  logic          cand_found;
  logic [IW-1:0] cand;
  logic [IW-1:0] idx_w;

  function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] v);
    return (v == IW'(NREQ - 1)) ? '0 : v + IW'(1);
  endfunction

  // First requesting index at or above rr_ptr, with wrap.
  always_comb begin
    cand_found = 1'b0;
    cand       = rr_ptr;
    idx_w      = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      idx_w = IW'((int'(rr_ptr) + k) % NREQ);
      if (!cand_found && job_req[idx_w]) begin
        cand_found = 1'b1;
        cand       = idx_w;
      end
    end
  end

  assign word_last = nm ? 7'(SIZE_W + SIZE_X - 1) : 7'(SIZE_X - 1);

  always_comb begin
    state_nxt        = state;
    rr_nxt           = rr_ptr;
    owner_nxt        = owner;
    nm_nxt           = nm;
    mat_valid_nxt    = mat_valid;
    mat_owner_nxt    = mat_owner;
    word_cnt_nxt     = word_cnt;
    res_cnt_nxt      = res_cnt;
    res_done         = 1'b0;
    job_ack          = '0;
    job_rej          = '0;
    in_ready         = '0;
    rsp_valid        = '0;
    rsp_data         = '0;
    eng_input_valid  = 1'b0;
    eng_input_data   = '0;
    eng_new_matrix   = 1'b0;
    eng_output_ready = 1'b0;

    // Outputs are forced quiet during the reset cycle so a mid-job reset
    // cannot leak an ack or a result while the registers are being cleared.
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (cand_found) begin
            if (job_new_matrix[cand] || (mat_valid && (mat_owner == cand))) begin
              job_ack[cand] = 1'b1;
              owner_nxt     = cand;
              nm_nxt        = job_new_matrix[cand];
              word_cnt_nxt  = '0;
              res_cnt_nxt   = '0;
              state_nxt     = LOAD;
            end else begin
              job_rej[cand] = 1'b1;
              rr_nxt        = inc_mod(cand);
            end
          end
        end

        LOAD: begin
          eng_input_valid = in_valid[owner];
          in_ready[owner] = eng_input_ready;
          eng_input_data  = in_data[owner*WIDTH_IN +: WIDTH_IN];
          eng_new_matrix  = nm;
          if (in_valid[owner] && eng_input_ready) begin
            word_cnt_nxt = word_cnt + 7'd1;
            if (word_cnt == word_last) begin
              state_nxt = DRAIN;
              if (nm) begin
                mat_valid_nxt = 1'b1;
                mat_owner_nxt = owner;
              end
            end
          end
        end

        DRAIN: begin
          rsp_valid[owner] = eng_output_valid;
          eng_output_ready = rsp_ready[owner];
          rsp_data         = eng_output_data;
          if (eng_output_valid && rsp_ready[owner]) begin
            res_cnt_nxt = res_cnt + 3'd1;
            res_done    = (res_cnt == 3'(SIZE_X - 1));
            if (res_done) begin
              state_nxt = IDLE;
              rr_nxt    = inc_mod(owner);
            end
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      mat_owner <= '0;
      mat_valid <= 1'b0;
      nm        <= 1'b0;
      word_cnt  <= '0;
      res_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      owner     <= owner_nxt;
      mat_owner <= mat_owner_nxt;
      mat_valid <= mat_valid_nxt;
      nm        <= nm_nxt;
      word_cnt  <= word_cnt_nxt;
      res_cnt   <= res_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_matvec_job_arbiter.sv
// Testbench for matvec_job_arbiter: directed job sequences against a small
// behavioural matvec8 engine. Expected results are closed-form values:
//   W word k = k+1 (row-major), X = 1..8  -> y[r] = 288*r + 204
//   same W, X = all 2                       -> y[r] = 128*r + 72
module tb_matvec_job_arbiter;

  localparam int NREQ = 2;
  localparam int WI   = 14;
  localparam int WO   = 28;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     job_req, job_new_matrix, job_ack, job_rej;
  logic [NREQ-1:0]     in_valid, in_ready, rsp_valid, rsp_ready;
  logic [NREQ*WI-1:0]  in_data;
  logic [WO-1:0]       rsp_data;
  logic                busy;
  logic                eng_input_valid, eng_input_ready, eng_new_matrix;
  logic                eng_output_valid, eng_output_ready;
  logic [WI-1:0]       eng_input_data;
  logic [WO-1:0]       eng_output_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  matvec_job_arbiter #(
    .NREQ(NREQ), .WIDTH_IN(WI), .WIDTH_OUT(WO), .SIZE_W(64), .SIZE_X(8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .job_req          (job_req),
    .job_new_matrix   (job_new_matrix),
    .job_ack          (job_ack),
    .job_rej          (job_rej),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .busy             (busy),
    .eng_input_valid  (eng_input_valid),
    .eng_input_ready  (eng_input_ready),
    .eng_input_data   (eng_input_data),
    .eng_new_matrix   (eng_new_matrix),
    .eng_output_valid (eng_output_valid),
    .eng_output_ready (eng_output_ready),
    .eng_output_data  (eng_output_data)
  );

  // Behavioural engine: takes 64 matrix words when new_matrix is set, then
  // 8 vector words, then presents 8 results.
  logic [WI-1:0] w_mem [64];
  logic [WI-1:0] x_mem [8];
  int            mcnt, xcnt, ocnt;
  logic          omode;

  always @(posedge clk) begin
    if (reset) begin
      mcnt  <= 0;
      xcnt  <= 0;
      ocnt  <= 0;
      omode <= 1'b0;
    end else if (omode) begin
      if (eng_output_ready) begin
        if (ocnt == 7) begin
          ocnt  <= 0;
          omode <= 1'b0;
        end else begin
          ocnt <= ocnt + 1;
        end
      end
    end else if (eng_input_valid) begin
      if (eng_new_matrix && mcnt < 64) begin
        w_mem[mcnt] <= eng_input_data;
        mcnt        <= mcnt + 1;
      end else begin
        x_mem[xcnt] <= eng_input_data;
        if (xcnt == 7) begin
          xcnt  <= 0;
          mcnt  <= 0;
          omode <= 1'b1;
        end else begin
          xcnt <= xcnt + 1;
        end
      end
    end
  end

  assign eng_input_ready  = !omode;
  assign eng_output_valid = omode;

  always_comb begin
    eng_output_data = '0;
    for (int c = 0; c < 8; c++)
      eng_output_data = eng_output_data + WO'(w_mem[ocnt*8 + c]) * WO'(x_mem[c]);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WI-1:0] word_of(input logic nm, input int xmode, input int k);
    int j;
    j = k;
    if (nm) begin
      if (k < 64) return WI'(k + 1);
      j = k - 64;
    end
    return (xmode == 0) ? WI'(j + 1) : WI'(2);
  endfunction

  // Entered at a negedge; leaves at the next negedge with the request dropped.
  task automatic do_req(input int r, input logic nm,
                        input logic [NREQ-1:0] exp_ack, input logic [NREQ-1:0] exp_rej);
    job_req[r]        = 1'b1;
    job_new_matrix[r] = nm;
    #1;
    chk("job_ack", job_ack, exp_ack);
    chk("job_rej", job_rej, exp_rej);
    @(negedge clk);
    job_req[r]        = 1'b0;
    job_new_matrix[r] = 1'b0;
  endtask

  // Streams the job's words from requester r; stalls three cycles early on.
  // stop_at >= 0 ends the stream after that many handshakes.
  task automatic feed(input int r, input logic nm, input int xmode, input int stop_at);
    int total, hs, nmhs, cyc;
    logic [WI-1:0] w;
    total = nm ? 72 : 8;
    if (stop_at >= 0) total = stop_at;
    hs = 0; nmhs = 0; cyc = 0;
    while (hs < total && cyc < 400) begin
      w = word_of(nm, xmode, hs);
      in_valid[r]         = !(cyc >= 10 && cyc < 13);
      in_data[r*WI +: WI] = w;
      #1;
      if (cyc < 14) begin
        chk("busy_load", busy, 1);
        chk("eng_in_valid", eng_input_valid, in_valid[r]);
        chk("ready_other", in_ready[1-r], 0);
        chk("eng_nm_level", eng_new_matrix, nm);
      end
      if (in_valid[r] && in_ready[r]) begin
        chk("eng_in_data", eng_input_data, w);
        hs++;
        if (eng_new_matrix) nmhs++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid[r] = 1'b0;
    if (stop_at < 0) begin
      chk("load_handshakes", hs, total);
      chk("nm_handshakes", nmhs, nm ? 72 : 0);
      #1;
      chk("eng_nm_after", eng_new_matrix, 0);
      chk("eng_valid_after", eng_input_valid, 0);
    end
  endtask

  task automatic drain(input int r, input int base, input int step, input bit bp);
    int n, cyc;
    n = 0; cyc = 0;
    rsp_ready[1-r] = 1'b1;
    while (n < 8 && cyc < 100) begin
      rsp_ready[r] = bp ? ~cyc[0] : 1'b1;
      #1;
      chk("eng_out_ready", eng_output_ready, rsp_ready[r]);
      chk("rsp_other", rsp_valid[1-r], 0);
      if (rsp_valid[r] && rsp_ready[r]) begin
        chk("rsp_data", rsp_data, base + step*n);
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    rsp_ready = '0;
    chk("rsp_count", n, 8);
    #1;
    chk("busy_end", busy, 0);
    chk("rsp_after", rsp_valid, 0);
  endtask

  task automatic apply_reset();
    reset          = 1'b1;
    job_req        = '0;
    job_new_matrix = '0;
    in_valid       = '0;
    in_data        = '0;
    rsp_ready      = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_outs", {busy, job_ack, job_rej, in_ready, rsp_valid, eng_input_valid,
                     eng_new_matrix, eng_output_ready}, 0);
    chk("rst_data", {rsp_data, eng_input_data}, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    apply_reset();

    // Cold reuse: nothing owned yet.
    do_req(0, 1'b0, 2'b00, 2'b01);
    #1;
    chk("cold_busy", busy, 0);
    chk("cold_eng", eng_input_valid, 0);
    @(negedge clk);

    // Full job by requester 0, then reuse by the owner.
    do_req(0, 1'b1, 2'b01, 2'b00);
    feed(0, 1'b1, 0, -1);
    drain(0, 204, 288, 1'b0);
    @(negedge clk);
    do_req(0, 1'b0, 2'b01, 2'b00);
    feed(0, 1'b0, 1, -1);
    drain(0, 72, 128, 1'b0);
    @(negedge clk);

    // Foreign reuse refused; requester 1 loads its own matrix with
    // result backpressure; requester 0 then loses its reuse right.
    do_req(1, 1'b0, 2'b00, 2'b10);
    do_req(1, 1'b1, 2'b10, 2'b00);
    feed(1, 1'b1, 0, -1);
    drain(1, 204, 288, 1'b1);
    @(negedge clk);
    do_req(0, 1'b0, 2'b00, 2'b01);

    // Round-robin contention from reset.
    apply_reset();
    job_req        = 2'b11;
    job_new_matrix = 2'b11;
    #1;
    chk("rr_first_ack", job_ack, 2'b01);
    chk("rr_first_rej", job_rej, 2'b00);
    @(negedge clk);
    job_req[0]        = 1'b0;
    job_new_matrix[0] = 1'b0;
    feed(0, 1'b1, 0, -1);
    drain(0, 204, 288, 1'b0);
    chk("rr_second_ack", job_ack, 2'b10);
    @(negedge clk);
    job_req        = '0;
    job_new_matrix = '0;
    feed(1, 1'b1, 1, -1);
    drain(1, 72, 128, 1'b0);
    @(negedge clk);
    job_req        = 2'b11;
    job_new_matrix = 2'b11;
    #1;
    chk("rr_third_ack", job_ack, 2'b01);
    @(negedge clk);
    job_req        = '0;
    job_new_matrix = '0;

    // Reset at word 30 of that load.
    feed(0, 1'b1, 0, 30);
    chk("mid_busy", busy, 1);
    reset    = 1'b1;
    in_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_outs", {busy, job_ack, job_rej, in_ready, rsp_valid, eng_input_valid,
                       eng_new_matrix, eng_output_ready}, 0);
    @(negedge clk);
    do_req(0, 1'b0, 2'b00, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
